// File: rtl/neuron_grid_controller_1x1.sv
// Timestep sequencer for the 1x1 neuron grid datapath: walks every neuron and axon
// per accepted tick and drives the datapath's counter and integrate/update controls.
module neuron_grid_controller_1x1 #(
    parameter int NEURON_COUNT = 256,
    parameter int AXON_COUNT   = 256
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic local_buffers_full,
    input  logic done_axon,
    input  logic done_neuron,
    output logic initial_axon_num,
    output logic inc_axon_num,
    output logic initial_neuron_num,
    output logic inc_neuron_num,
    output logic new_neuron,
    output logic process_spike,
    output logic update_potential,
    output logic busy,
    output logic step_done,
    output logic tick_dropped,
    output logic seq_error
);

    localparam int AX_W = (AXON_COUNT > 1) ? $clog2(AXON_COUNT) : 1;
    localparam int NR_W = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1;
    localparam logic [AX_W-1:0] AX_LAST = AX_W'(AXON_COUNT - 1);
    localparam logic [NR_W-1:0] NR_LAST = NR_W'(NEURON_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_NEW,
        S_PROC,
        S_UPD,
        S_NEXT,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [AX_W-1:0] ax, ax_nxt;
    logic [NR_W-1:0] nr, nr_nxt;
    logic            pending, pending_nxt;
    logic            tick_dropped_nxt;
    logic            seq_error_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            ax           <= '0;
            nr           <= '0;
            pending      <= 1'b0;
            tick_dropped <= 1'b0;
            seq_error    <= 1'b0;
        end else begin
            state        <= state_nxt;
            ax           <= ax_nxt;
            nr           <= nr_nxt;
            pending      <= pending_nxt;
            tick_dropped <= tick_dropped_nxt;
            seq_error    <= seq_error_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        ax_nxt             = ax;
        nr_nxt             = nr;
        pending_nxt        = pending;
        tick_dropped_nxt   = tick_dropped;
        seq_error_nxt      = seq_error;
        initial_axon_num   = 1'b0;
        inc_axon_num       = 1'b0;
        initial_neuron_num = 1'b0;
        inc_neuron_num     = 1'b0;
        new_neuron         = 1'b0;
        process_spike      = 1'b0;
        update_potential   = 1'b0;
        step_done          = 1'b0;
        busy               = (state != S_IDLE);

        // A tick arriving mid-timestep is queued once; a second one is lost and flagged.
        if (tick && (state != S_IDLE)) begin
            if (pending) begin
                tick_dropped_nxt = 1'b1;
            end else begin
                pending_nxt = 1'b1;
            end
        end

        case (state)
            S_IDLE: begin
                if (tick || pending) begin
                    state_nxt   = S_INIT;
                    pending_nxt = 1'b0;
                end
            end
            S_INIT: begin
                initial_neuron_num = 1'b1;
                nr_nxt             = '0;
                state_nxt          = S_NEW;
            end
            S_NEW: begin
                new_neuron       = 1'b1;
                initial_axon_num = 1'b1;
                ax_nxt           = '0;
                state_nxt        = S_PROC;
            end
            S_PROC: begin
                process_spike = 1'b1;
                if (ax == AX_LAST) begin
                    state_nxt = S_UPD;
                    if (!done_axon) begin
                        seq_error_nxt = 1'b1;
                    end
                end else begin
                    inc_axon_num = 1'b1;
                    ax_nxt       = ax + AX_W'(1);
                end
            end
            S_UPD: begin
                update_potential = ~local_buffers_full;
                if (!local_buffers_full) begin
                    if (nr == NR_LAST) begin
                        state_nxt = S_DONE;
                        if (!done_neuron) begin
                            seq_error_nxt = 1'b1;
                        end
                    end else begin
                        state_nxt = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                inc_neuron_num = 1'b1;
                nr_nxt         = nr + NR_W'(1);
                state_nxt      = S_NEW;
            end
            S_DONE: begin
                step_done = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_neuron_grid_controller_1x1.sv
// Bench for neuron_grid_controller_1x1: a small (2x4) and a default (256x256) instance,
// each closed around a negedge-clocked datapath counter model.
module tb_neuron_grid_controller_1x1;

    localparam int SN = 2;
    localparam int SA = 4;
    localparam int BN = 256;
    localparam int BA = 256;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic tick_s = 1'b0;
    logic tick_b = 1'b0;
    logic full_s = 1'b0;
    logic full_b = 1'b0;
    logic force_ax0 = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic s_iax, s_incax, s_inr, s_incnr, s_new, s_ps, s_up, s_busy, s_sd, s_td, s_se;
    logic b_iax, b_incax, b_inr, b_incnr, b_new, b_ps, b_up, b_busy, b_sd, b_td, b_se;
    logic s_done_axon, s_done_neuron, b_done_axon, b_done_neuron;
    int   s_axon_num, s_neuron_num, b_axon_num, b_neuron_num;

    neuron_grid_controller_1x1 #(.NEURON_COUNT(SN), .AXON_COUNT(SA)) dut_s (
        .clk(clk), .reset_n(reset_n), .tick(tick_s), .local_buffers_full(full_s),
        .done_axon(s_done_axon), .done_neuron(s_done_neuron),
        .initial_axon_num(s_iax), .inc_axon_num(s_incax),
        .initial_neuron_num(s_inr), .inc_neuron_num(s_incnr),
        .new_neuron(s_new), .process_spike(s_ps), .update_potential(s_up),
        .busy(s_busy), .step_done(s_sd), .tick_dropped(s_td), .seq_error(s_se)
    );

    neuron_grid_controller_1x1 #(.NEURON_COUNT(BN), .AXON_COUNT(BA)) dut_b (
        .clk(clk), .reset_n(reset_n), .tick(tick_b), .local_buffers_full(full_b),
        .done_axon(b_done_axon), .done_neuron(b_done_neuron),
        .initial_axon_num(b_iax), .inc_axon_num(b_incax),
        .initial_neuron_num(b_inr), .inc_neuron_num(b_incnr),
        .new_neuron(b_new), .process_spike(b_ps), .update_potential(b_up),
        .busy(b_busy), .step_done(b_sd), .tick_dropped(b_td), .seq_error(b_se)
    );

    function automatic int cnt_next(input int cur, input logic clr, input logic inc);
        if (clr) return 0;
        if (inc) return cur + 1;
        return cur;
    endfunction

    // Datapath counters move on the falling edge, as in neuron_grid_datapath_1x1.
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_axon_num    <= 0;
            s_neuron_num  <= 0;
            s_done_neuron <= 1'b0;
            b_axon_num    <= 0;
            b_neuron_num  <= 0;
            b_done_neuron <= 1'b0;
        end else begin
            s_axon_num    <= cnt_next(s_axon_num, s_iax, s_incax);
            s_neuron_num  <= cnt_next(s_neuron_num, s_inr, s_incnr);
            s_done_neuron <= (cnt_next(s_neuron_num, s_inr, s_incnr) == SN - 1);
            b_axon_num    <= cnt_next(b_axon_num, b_iax, b_incax);
            b_neuron_num  <= cnt_next(b_neuron_num, b_inr, b_incnr);
            b_done_neuron <= (cnt_next(b_neuron_num, b_inr, b_incnr) == BN - 1);
        end
    end

    assign s_done_axon = force_ax0 ? 1'b0 : (s_axon_num == SA - 1);
    assign b_done_axon = (b_axon_num == BA - 1);

    int s_ps_cnt = 0, s_up_cnt = 0, s_incnr_cnt = 0;
    int b_ps_cnt = 0, b_up_cnt = 0;
    int viol = 0;

    always @(negedge clk) begin
        #3;
        if (s_ps) s_ps_cnt <= s_ps_cnt + 1;
        if (s_up) s_up_cnt <= s_up_cnt + 1;
        if (s_incnr) s_incnr_cnt <= s_incnr_cnt + 1;
        if (b_ps) b_ps_cnt <= b_ps_cnt + 1;
        if (b_up) b_up_cnt <= b_up_cnt + 1;
        if (($countones({s_iax, s_incax, s_inr, s_incnr}) > 1) || (s_ps && s_new) ||
            ($countones({b_iax, b_incax, b_inr, b_incnr}) > 1) || (b_ps && b_new))
            viol <= viol + 1;
    end

    int pass_cnt = 0;
    int check_cnt = 0;
    int q_s[$];
    int q_b[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_sd(input bit big, input int budget, input string tag);
        bit seen;
        int exp;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (big ? b_sd : s_sd) begin
                seen = 1'b1;
                break;
            end
        end
        exp = -1;
        if (big) begin
            if (q_b.size() > 0) exp = q_b.pop_front();
        end else begin
            if (q_s.size() > 0) exp = q_s.pop_front();
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) chk({tag, "_cycle"}, 32'(cyc), 32'(exp));
    endtask

    function automatic logic [10:0] s_outs();
        return {s_iax, s_incax, s_inr, s_incnr, s_new, s_ps, s_up, s_busy, s_sd, s_td, s_se};
    endfunction

    int t0, ps0, up0, nr0;

    initial begin
        #1 reset_n = 1'b0;
        step(); step(); step();
        chk("reset_small_outs", 32'(s_outs()), 32'd0);
        chk("reset_big_busy", 32'(b_busy), 32'd0);
        reset_n = 1'b1;
        step();
        chk("idle_small_outs", 32'(s_outs()), 32'd0);

        // Plain timestep, no back-pressure
        ps0 = s_ps_cnt; up0 = s_up_cnt; nr0 = s_incnr_cnt;
        tick_s = 1'b1; t0 = cyc; q_s.push_back(t0 + 15);
        step(); tick_s = 1'b0;
        chk("t1_init", 32'({s_busy, s_inr}), 32'b11);
        step();
        chk("t1_new", 32'({s_new, s_iax, s_ps}), 32'b110);
        wait_sd(1'b0, 20, "t1_done");
        chk("t1_ps_cycles", 32'(s_ps_cnt - ps0), 32'd8);
        chk("t1_up_pulses", 32'(s_up_cnt - up0), 32'd2);
        chk("t1_incnr_pulses", 32'(s_incnr_cnt - nr0), 32'd1);
        step();
        chk("t1_idle_after", 32'(s_busy), 32'd0);

        // Three-cycle stall on the first update
        tick_s = 1'b1; t0 = cyc; q_s.push_back(t0 + 18);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) tick_s = 1'b0;
            if (k == 6) full_s = 1'b1;
            if (k >= 7 && k <= 9)
                chk("t2_stall_quiet", 32'({s_ps, s_new, s_iax, s_incax, s_inr, s_incnr, s_up, s_sd, s_busy}), 32'd1);
            if (k == 10) begin
                full_s = 1'b0;
                #1;
                chk("t2_up_after_stall", 32'(s_up), 32'd1);
            end
        end
        wait_sd(1'b0, 20, "t2_done");
        step();

        // Ticks at cycles 0, 5, 6: one queued, one dropped
        chk("t3_dropped_before", 32'(s_td), 32'd0);
        tick_s = 1'b1; t0 = cyc; q_s.push_back(t0 + 15); q_s.push_back(t0 + 31);
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) tick_s = 1'b0;
            if (k == 5) tick_s = 1'b1;
            if (k == 6) chk("t3_dropped_pending", 32'(s_td), 32'd0);
            if (k == 7) begin
                tick_s = 1'b0;
                chk("t3_dropped_set", 32'(s_td), 32'd1);
            end
        end
        wait_sd(1'b0, 20, "t3_first_done");
        step();
        chk("t3_idle_gap", 32'(s_busy), 32'd0);
        step();
        chk("t3_restart_init", 32'({s_busy, s_inr}), 32'b11);
        wait_sd(1'b0, 30, "t3_second_done");
        step();

        // done_axon never asserted
        chk("t4_seq_before", 32'(s_se), 32'd0);
        force_ax0 = 1'b1;
        tick_s = 1'b1; t0 = cyc; q_s.push_back(t0 + 15);
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) tick_s = 1'b0;
            if (k == 6) chk("t4_seq_last_proc", 32'(s_se), 32'd0);
            if (k == 7) chk("t4_seq_set", 32'(s_se), 32'd1);
        end
        wait_sd(1'b0, 20, "t4_done");
        force_ax0 = 1'b0;
        step();

        // Asynchronous reset in the middle of PROC
        tick_s = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) tick_s = 1'b0;
        end
        chk("t5_in_proc", 32'(s_ps), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_reset_outs", 32'(s_outs()), 32'd0);
        step(); step();
        reset_n = 1'b1;
        step();
        chk("t5_after_release", 32'(s_outs()), 32'd0);
        tick_s = 1'b1; t0 = cyc; q_s.push_back(t0 + 15);
        step(); tick_s = 1'b0;
        chk("t5_restart_init", 32'(s_inr), 32'd1);
        wait_sd(1'b0, 20, "t5_done");
        chk("t5_flags_clear", 32'({s_td, s_se}), 32'd0);
        step();

        // Full-size core against the datapath model
        ps0 = b_ps_cnt; up0 = b_up_cnt;
        tick_b = 1'b1; t0 = cyc; q_b.push_back(t0 + 66305);
        step(); tick_b = 1'b0;
        wait_sd(1'b1, 67000, "t6_done");
        chk("t6_seq_error", 32'(b_se), 32'd0);
        chk("t6_ps_cycles", 32'(b_ps_cnt - ps0), 32'd65536);
        chk("t6_up_pulses", 32'(b_up_cnt - up0), 32'd256);
        step();
        chk("t6_idle_after", 32'(b_busy), 32'd0);

        chk("ctrl_exclusive", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
